// File: rtl/median_window_scheduler.sv
// -----------------------------------------------------------------------------
// median_window_scheduler
//
// Purpose: streams a raster-order 8-bit frame of IMG_W x IMG_H pixels, builds a
// 3x3 sliding window from two line buffers plus a window register, and emits
// the median of every interior window ((IMG_W-2)*(IMG_H-2) outputs per frame)
// through a valid/ready output register with latency 1.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   start      in   1  one-cycle frame request (ignored unless idle)
//   in_pixel   in   8  raster-order input pixel
//   in_valid   in   1  in_pixel valid
//   in_ready   out  1  block accepts in_pixel this cycle
//   out_pixel  out  8  3x3 median of the current interior window
//   out_valid  out  1  out_pixel valid
//   out_ready  in   1  downstream accepts out_pixel
//   bypass     in   1  (only with MEDIAN_SCHED_BYPASS_EN) output window centre
//   busy       out  1  frame in progress
//   done       out  1  one-cycle pulse after the frame's last output transfers
//
// Optional feature macro: MEDIAN_SCHED_BYPASS_EN adds the bypass input.
// -----------------------------------------------------------------------------
module median_window_scheduler #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_pixel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_pixel,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef MEDIAN_SCHED_BYPASS_EN
    input  logic       bypass,
`endif
    output logic       busy,
    output logic       done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Line buffers are shift chains: index 0 is the newest entry, index
    // IMG_W-2 the oldest. lb1 delays the window's bottom-right pixel, lb0 the
    // middle-right pixel, so their tails are the pixels one and two rows above
    // the incoming pixel at the same column.
    logic [7:0] lb0 [IMG_W-1];
    logic [7:0] lb1 [IMG_W-1];
    logic [7:0] win [3][3];        // win[row][col], row 0 oldest, col 0 leftmost

    logic [7:0]  col_new [3];
    logic [71:0] win_bus;
    logic [7:0]  result;
    logic        accept;
    logic        interior;
    logic        last_col;
    logic        last_pixel;

    // Sorting nine bytes and taking the middle one is the 3x3 median.
    function automatic logic [7:0] median9(input logic [71:0] w);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int k = 0; k < 9; k++) a[k] = w[k*8 +: 8];
        for (int p = 0; p < 8; p++) begin
            for (int q = 0; q < 8 - p; q++) begin
                if (a[q] > a[q+1]) begin
                    t      = a[q];
                    a[q]   = a[q+1];
                    a[q+1] = t;
                end
            end
        end
        return a[4];
    endfunction

    // NOTE: every signal driven from always_comb gets a default assignment
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        in_ready   = (state == RUN) && (!out_valid || out_ready);
        accept     = in_valid && in_ready;
        interior   = (row >= ROW_W'(2)) && (col >= COL_W'(2));
        last_col   = (col == COL_W'(IMG_W - 1));
        last_pixel = last_col && (row == ROW_W'(IMG_H - 1));

        col_new[0] = lb0[IMG_W-2];
        col_new[1] = lb1[IMG_W-2];
        col_new[2] = in_pixel;

        // Window as it will look once the incoming pixel is shifted in, so the
        // registered result belongs to the pixel accepted this cycle.
        win_bus = '0;
        for (int i = 0; i < 3; i++) begin
            win_bus[i*24 +  0 +: 8] = win[i][1];
            win_bus[i*24 +  8 +: 8] = win[i][2];
            win_bus[i*24 + 16 +: 8] = col_new[i];
        end

`ifdef MEDIAN_SCHED_BYPASS_EN
        result = bypass ? win_bus[39:32] : median9(win_bus);
`else
        result = median9(win_bus);
`endif
    end

    // NOTE: line buffers and the window are data storage with no reset; the
    // row/col gating ensures every output only reads pixels pushed during the
    // current frame, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[0] <= win[1][2];
            lb1[0] <= win[2][2];
            for (int k = 1; k < IMG_W - 1; k++) begin
                lb0[k] <= lb0[k-1];
                lb1[k] <= lb1[k-1];
            end
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
                win[i][2] <= col_new[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            // A new result takes priority; otherwise a transfer empties the
            // register, and a stalled output simply holds.
            if (accept && interior) begin
                out_valid <= 1'b1;
                out_pixel <= result;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_pixel ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                RUN: begin
                    if (accept && last_pixel) state <= FLUSH;
                end
                FLUSH: begin
                    // The last pixel is interior, so its result is pending here.
                    if (out_valid && out_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median_window_scheduler.sv
// -----------------------------------------------------------------------------
// tb_median_window_scheduler
//
// Directed bench: a 4x4 instance exercises ramp frames, a spike frame, output
// back-pressure, start while busy and mid-frame reset; an 8x8 instance runs an
// all-zero frame with a single 255 impulse. Bypass frames run only when
// MEDIAN_SCHED_BYPASS_EN is defined.
// -----------------------------------------------------------------------------
module tb_median_window_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start4, in_valid4, in_ready4, out_valid4, out_ready4, busy4, done4;
    logic [7:0] in_pixel4, out_pixel4;
    logic       start8, in_valid8, in_ready8, out_valid8, out_ready8, busy8, done8;
    logic [7:0] in_pixel8, out_pixel8;
`ifdef MEDIAN_SCHED_BYPASS_EN
    logic       byp4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ramp      [16];
    logic [7:0] spike     [16];
    logic [7:0] ramp_med  [4];
    logic [7:0] spike_med [4];
    logic [7:0] spike_ctr [4];

    median_window_scheduler #(.IMG_W(4), .IMG_H(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .in_pixel  (in_pixel4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .out_pixel (out_pixel4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
`ifdef MEDIAN_SCHED_BYPASS_EN
        .bypass    (byp4),
`endif
        .busy      (busy4),
        .done      (done4)
    );

    median_window_scheduler #(.IMG_W(8), .IMG_H(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .in_pixel  (in_pixel8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .out_pixel (out_pixel8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
`ifdef MEDIAN_SCHED_BYPASS_EN
        .bypass    (1'b0),
`endif
        .busy      (busy8),
        .done      (done8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one 4x4 frame. stall > 0 holds out_ready low for that many cycles
    // once the first output appears; mid_start pulses start while busy.
    task automatic frame4(input string tag, input logic [7:0] pix [16],
                          input logic [7:0] exp [4], input int stall, input bit mid_start);
        int         idx;
        int         stall_left;
        bit         seen_done;
        logic       busy_at_done;
        logic [7:0] got [$];
        idx          = 0;
        stall_left   = stall;
        seen_done    = 1'b0;
        busy_at_done = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check({tag, " busy after start"}, busy4, 1);
        for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
            in_valid4 = (idx < 16);
            in_pixel4 = 8'd0;
            if (idx < 16) in_pixel4 = pix[idx];
            start4     = mid_start && (idx == 6);
            out_ready4 = !(stall_left > 0 && out_valid4);
            #1;
            if (done4) begin
                seen_done    = 1'b1;
                busy_at_done = busy4;
            end
            if (!out_ready4) begin
                check({tag, " stall hold pixel"}, out_pixel4, exp[0]);
                check({tag, " stall in_ready"}, in_ready4, 0);
                stall_left--;
            end else if (out_valid4) begin
                got.push_back(out_pixel4);
            end
            if (in_valid4 && in_ready4) idx++;
            @(negedge clk);
        end
        in_valid4  = 1'b0;
        start4     = 1'b0;
        out_ready4 = 1'b1;
        check({tag, " done seen"}, seen_done, 1);
        check({tag, " busy low with done"}, busy_at_done, 0);
        check({tag, " output count"}, got.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s out%0d", tag, k),
                  (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, exp[k]);
        #1;
        check({tag, " done one cycle"}, done4, 0);
        @(negedge clk);
    endtask

    // 8x8 all-zero frame with a single 255 at (3,3): every median is zero.
    task automatic frame8_impulse();
        int idx;
        int cnt;
        int nonzero;
        bit seen_done;
        idx       = 0;
        cnt       = 0;
        nonzero   = 0;
        seen_done = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            in_valid8  = (idx < 64);
            in_pixel8  = (idx == 27) ? 8'd255 : 8'd0;
            out_ready8 = 1'b1;
            #1;
            if (done8) seen_done = 1'b1;
            if (out_valid8) begin
                cnt++;
                if (out_pixel8 != 8'd0) nonzero++;
            end
            if (in_valid8 && in_ready8) idx++;
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        check("impulse8 done seen", seen_done, 1);
        check("impulse8 output count", cnt, 36);
        check("impulse8 nonzero outputs", nonzero, 0);
        check("impulse8 busy after frame", busy8, 0);
    endtask

    initial begin
        rst = 1'b1;
        start4 = 1'b0; in_valid4 = 1'b0; in_pixel4 = 8'd0; out_ready4 = 1'b1;
        start8 = 1'b0; in_valid8 = 1'b0; in_pixel8 = 8'd0; out_ready8 = 1'b1;
`ifdef MEDIAN_SCHED_BYPASS_EN
        byp4 = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            ramp[i]  = 8'(i);
            spike[i] = 8'(i);
        end
        spike[5]  = 8'd200;
        ramp_med  = '{8'd5,   8'd6, 8'd9,  8'd10};
        spike_med = '{8'd6,   8'd7, 8'd10, 8'd11};
        spike_ctr = '{8'd200, 8'd6, 8'd9,  8'd10};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid4, 0);
        check("reset out_pixel", out_pixel4, 0);
        check("reset in_ready", in_ready4, 0);
        check("reset busy", busy4, 0);
        check("reset done", done4, 0);
        check("reset busy8", busy8, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle in_ready", in_ready4, 0);

        // Ramp 0..15: medians 5, 6, 9, 10
        frame4("ramp", ramp, ramp_med, 0, 1'b0);
        // Spike at (1,1) pulls every median upward by one rank
        frame4("spike", spike, spike_med, 0, 1'b0);
        // Back-pressure on the first output
        frame4("stall", ramp, ramp_med, 5, 1'b0);
        // start while busy is ignored
        frame4("start busy", ramp, ramp_med, 0, 1'b1);

        // Reset after 7 pixels of a frame
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid4 = 1'b1;
            in_pixel4 = 8'(i);
            @(negedge clk);
        end
        in_pixel4 = 8'd7;
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        in_valid4 = 1'b0;
        #1;
        check("midreset busy", busy4, 0);
        check("midreset out_valid", out_valid4, 0);
        check("midreset out_pixel", out_pixel4, 0);
        check("midreset in_ready", in_ready4, 0);
        check("midreset done", done4, 0);
        @(negedge clk);
        frame4("after reset", ramp, ramp_med, 0, 1'b0);

        frame8_impulse();

`ifdef MEDIAN_SCHED_BYPASS_EN
        byp4 = 1'b1;
        frame4("bypass ramp", ramp, ramp_med, 0, 1'b0);
        frame4("bypass spike", spike, spike_ctr, 0, 1'b0);
        byp4 = 1'b0;
        frame4("median spike", spike, spike_med, 0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
